stream_mux: RTL and testbench

Parametrised N-way multiplexer with valid/ready handshakes and a registered output stage. It generalises the fixed two- and four-input combinational multiplexers to N channels. It adds two selection modes: explicit select and round-robin arbitration. It sits between datapath producers (register-file read ports, ALU result sources, memory responses) and a single consumer that may stall.

---
 rtl/stream_mux.sv | 125 ++++++++++++
 tb/tb_stream_mux.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// N-way valid/ready stream multiplexer with a single registered output stage.
// Channel choice is either an explicit select or round-robin arbitration.

module stream_mux_lane #(
  parameter int WIDTH = 32,
  parameter int SW    = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             load,
  input  logic             cand_ok,
  input  logic [SW-1:0]    cand,
  output logic             ready,
  output logic             take,
  output logic [WIDTH-1:0] gated
);
  logic hit;

  assign hit   = cand_ok && (cand == SW'(IDX));
  assign ready = load && hit;
  assign take  = ready && valid;
  // Zero unless this lane transfers, so lanes can be OR-combined.
  assign gated = take ? data : '0;
endmodule

module stream_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_chan,
  output logic               out_valid,
  input  logic               out_ready
);
  logic                      load;
  logic [SW-1:0]             cand;
  logic                      cand_ok;
  logic                      cand_live;
  logic [SW-1:0]             last;
  logic [N-1:0]              take;
  logic [N-1:0][WIDTH-1:0]   gated;
  logic [WIDTH-1:0]          nxt_data;
  logic                      xfer;
  logic                      unused_ok;

  assign load = !out_valid || out_ready;

  generate
    if (MODE == 0) begin : g_sel
      always_comb begin
        cand    = sel;
        cand_ok = {1'b0, sel} < (SW+1)'(N);
      end
    end else begin : g_rr
      // Search upward from the channel after the last one served, wrapping.
      always_comb begin
        int idx;
        cand    = '0;
        cand_ok = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (int'(last) + k) % N;
          if (!cand_ok && in_valid[idx]) begin
            cand_ok = 1'b1;
            cand    = SW'(idx);
          end
        end
      end
    end
  endgenerate

  // Transfers are suppressed while reset is high.
  assign cand_live = cand_ok && !reset;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      stream_mux_lane #(.WIDTH(WIDTH), .SW(SW), .IDX(i)) u_lane (
        .data    (in_data[i*WIDTH +: WIDTH]),
        .valid   (in_valid[i]),
        .load    (load),
        .cand_ok (cand_live),
        .cand    (cand),
        .ready   (in_ready[i]),
        .take    (take[i]),
        .gated   (gated[i])
      );
    end
  endgenerate

  always_comb begin
    nxt_data = '0;
    for (int k = 0; k < N; k++) nxt_data = nxt_data | gated[k];
  end

  assign xfer = |take;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SW'(N-1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= nxt_data;
      out_chan  <= cand;
      if (MODE != 0) last <= cand;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // sel is ignored in round-robin mode and last in select mode.
  assign unused_ok = &{1'b0, sel, last};
endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: select mode (N=4, N=3) and round-robin (N=4).
`timescale 1ns/1ps

module tb_stream_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // dut0: MODE 0, N=4
  logic [31:0] d0 = '0; logic [3:0] v0 = '0; logic [3:0] r0; logic [1:0] s0 = '0;
  logic [7:0] od0; logic [1:0] oc0; logic ov0; logic ordy0 = 1'b1;
  // dut1: MODE 1, N=4
  logic [31:0] d1 = '0; logic [3:0] v1 = '0; logic [3:0] r1; logic [1:0] s1 = '0;
  logic [7:0] od1; logic [1:0] oc1; logic ov1; logic ordy1 = 1'b1;
  // dut2: MODE 0, N=3
  logic [23:0] d2 = '0; logic [2:0] v2 = '0; logic [2:0] r2; logic [1:0] s2 = '0;
  logic [7:0] od2; logic [1:0] oc2; logic ov2; logic ordy2 = 1'b1;

  stream_mux #(.WIDTH(8), .N(4), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
    .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy0));
  stream_mux #(.WIDTH(8), .N(4), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
    .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy1));
  stream_mux #(.WIDTH(8), .N(3), .MODE(0)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
    .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(ordy2));

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] q [3][$];
  int last_m [3] = '{3, 3, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model for one DUT, evaluated just before the rising edge.
  task automatic step(input int d, input int mode, input int n, input logic [15:0] vld,
                      input logic [3:0] s, input logic [127:0] dat, input logic [15:0] rdy,
                      input logic ov, input logic [7:0] od, input logic [3:0] oc,
                      input logic ordy);
    logic [15:0] er;
    int g;
    bit has, ld, pend;
    pend = q[d].size() > 0;
    chk($sformatf("d%0d_out_valid", d), 32'(ov), 32'(pend));
    if (pend) begin
      chk($sformatf("d%0d_out_data", d), 32'(od), 32'(q[d][0][7:0]));
      chk($sformatf("d%0d_out_chan", d), 32'(oc), 32'(q[d][0][11:8]));
    end
    if (reset) begin
      chk($sformatf("d%0d_rdy_rst", d), 32'(rdy), 32'd0);
      q[d].delete();
      last_m[d] = n - 1;
      return;
    end
    ld = !pend || ordy;
    has = 0; g = 0;
    if (mode == 0) begin
      if (int'(s) < n) begin has = 1; g = int'(s); end
    end else begin
      for (int k = 1; k <= n; k++) begin
        int ix;
        ix = (last_m[d] + k) % n;
        if (!has && vld[ix]) begin has = 1; g = ix; end
      end
    end
    er = '0;
    if (ld && has) er[g] = 1'b1;
    chk($sformatf("d%0d_in_ready", d), 32'(rdy), 32'(er));
    if (pend && ordy) void'(q[d].pop_front());
    if (ld && has && vld[g]) begin
      q[d].push_back({g[3:0], dat[g*8 +: 8]});
      if (mode == 1) last_m[d] = g;
    end
  endtask

  always @(negedge clk) begin
    step(0, 0, 4, {12'b0, v0}, {2'b0, s0}, {96'b0, d0}, {12'b0, r0}, ov0, od0, {2'b0, oc0}, ordy0);
    step(1, 1, 4, {12'b0, v1}, {2'b0, s1}, {96'b0, d1}, {12'b0, r1}, ov1, od1, {2'b0, oc1}, ordy1);
    step(2, 0, 3, {13'b0, v2}, {2'b0, s2}, {104'b0, d2}, {13'b0, r2}, ov2, od2, {2'b0, oc2}, ordy2);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", 32'(od0), 32'd0);
    reset = 1'b0;

    // Explicit select sweep
    d0 = 32'h44332211; v0 = 4'hf; ordy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = 2'(i); #1;
      chk("sel_ready_onehot", 32'(r0), 32'(1 << i));
      tick();
      chk("sel_out_data", 32'(od0), 32'(8'h11 * (i + 1)));
      chk("sel_out_chan", 32'(oc0), 32'(i));
    end

    // Stall holds the beat; release loads the next one with no bubble
    s0 = 2'd1; tick();
    ordy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d0 = $urandom; s0 = 2'($urandom_range(0, 3)); tick();
      chk("stall_data", 32'(od0), 32'h22);
      chk("stall_valid", 32'(ov0), 32'd1);
      chk("stall_ready", 32'(r0), 32'd0);
    end
    ordy0 = 1'b1; d0 = 32'h44332211; s0 = 2'd2; tick();
    chk("release_data", 32'(od0), 32'h33);
    chk("release_valid", 32'(ov0), 32'd1);
    v0 = 4'h0; tick(); tick();

    // Round-robin from reset with all channels valid
    d1 = 32'hd4c3b2a1; v1 = 4'hf; ordy1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_chan", 32'(oc1), 32'(i % 4));
      chk("rr_valid", 32'(ov1), 32'd1);
    end
    // Only channels 1 and 3 valid
    v1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_alt_chan", 32'(oc1), (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    v1 = 4'h0; tick(); tick();

    // N=3 with out-of-range select
    d2 = 24'h332211; v2 = 3'b111; ordy2 = 1'b1; s2 = 2'd1; tick();
    s2 = 2'd3; #1;
    chk("oor_ready", 32'(r2), 32'd0);
    tick();
    chk("oor_valid", 32'(ov2), 32'd0);
    v2 = 3'b000; tick();

    // Reset while stalled discards the held beat
    d0 = 32'h44332211; v0 = 4'hf; s0 = 2'd2; ordy0 = 1'b0; tick();
    chk("pre_rst_data", 32'(od0), 32'h33);
    v1 = 4'hf; ordy1 = 1'b0; tick();
    v0 = 4'h0; reset = 1'b1; tick();
    chk("post_rst_valid", 32'(ov0), 32'd0);
    chk("post_rst_data", 32'(od0), 32'd0);
    chk("post_rst_chan", 32'(oc0), 32'd0);
    reset = 1'b0; ordy1 = 1'b1; tick();
    chk("post_rst_rr_chan", 32'(oc1), 32'd0);
    v1 = 4'h0; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
